// File: rtl/uart_rx_deser_param_if.sv
// Output-side handshake bundle of the Rx deserializer: completed word, its parity,
// and the valid/ready pair between the deserializer (master) and its consumer (slave).
interface uart_rx_deser_param_if #(
    parameter int MAX_WIDTH = 9
);
    logic [MAX_WIDTH-1:0] p_data;
    logic                 p_parity;
    logic                 p_valid;
    logic                 p_ready;

    modport master (
        output p_data,
        output p_parity,
        output p_valid,
        input  p_ready
    );

    modport slave (
        input  p_data,
        input  p_parity,
        input  p_valid,
        output p_ready
    );
endinterface

// File: rtl/uart_rx_deser_param.sv
// UART Rx deserializer: gathers strobed bits into a 5..MAX_WIDTH bit word (LSB- or
// MSB-first), tracks parity and hands the word out through a one-entry valid/ready register.
module uart_rx_deser_param #(
    parameter int MAX_WIDTH = 9,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sampled_bit,
    input  logic                 bit_strobe,
    input  logic                 deser_en,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     data_len,
    input  logic                 msb_first,
    input  logic                 overrun_clr,
    output logic                 overrun,
    output logic                 busy,
    uart_rx_deser_param_if.master out_if
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(5);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WIDTH);

    logic [0:0]           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [CNT_W-1:0]     len_q,      len_d;
    logic                 ord_q,      ord_d;
    logic [MAX_WIDTH-1:0] sreg_q,     sreg_d;
    logic                 par_q,      par_d;
    logic [MAX_WIDTH-1:0] p_data_q,   p_data_d;
    logic                 p_parity_q, p_parity_d;
    logic                 p_valid_q,  p_valid_d;
    logic                 overrun_q,  overrun_d;

    logic [CNT_W-1:0]     clamp_len;
    logic [CNT_W-1:0]     len_eff;
    logic                 ord_eff;
    logic [CNT_W-1:0]     wr_idx;
    logic                 capture;
    logic                 complete;
    logic                 overrun_set;

    always_comb begin
        clamp_len = data_len;
        if (data_len < MIN_LEN) begin
            clamp_len = MIN_LEN;
        end else if (data_len > MAX_LEN) begin
            clamp_len = MAX_LEN;
        end

        // Length and order are sampled on the first bit of a word and frozen until it ends.
        len_eff  = (state_q == IDLE) ? clamp_len : len_q;
        ord_eff  = (state_q == IDLE) ? msb_first : ord_q;
        wr_idx   = ord_eff ? (len_eff - CNT_W'(1) - cnt_q) : cnt_q;
        capture  = deser_en && bit_strobe && !abort;
        complete = capture && (cnt_q == len_eff - CNT_W'(1));

        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ord_d       = ord_q;
        sreg_d      = sreg_q;
        par_d       = par_q;
        p_data_d    = p_data_q;
        p_parity_d  = p_parity_q;
        p_valid_d   = p_valid_q;
        overrun_set = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
            par_d   = 1'b0;
        end else if (capture) begin
            len_d = len_eff;
            ord_d = ord_eff;
            for (int i = 0; i < MAX_WIDTH; i++) begin
                if (wr_idx == CNT_W'(i)) begin
                    sreg_d[i] = sampled_bit;
                end
            end
            par_d   = par_q ^ sampled_bit;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SHIFT;
            if (complete) begin
                p_data_d   = sreg_d;
                p_parity_d = par_d;
                state_d    = IDLE;
                cnt_d      = '0;
                sreg_d     = '0;
                par_d      = 1'b0;
            end
        end

        if (complete) begin
            p_valid_d   = 1'b1;
            overrun_set = p_valid_q && !out_if.p_ready;
        end else if (p_valid_q && out_if.p_ready) begin
            p_valid_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            ord_q      <= 1'b0;
            sreg_q     <= '0;
            par_q      <= 1'b0;
            p_data_q   <= '0;
            p_parity_q <= 1'b0;
            p_valid_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ord_q      <= ord_d;
            sreg_q     <= sreg_d;
            par_q      <= par_d;
            p_data_q   <= p_data_d;
            p_parity_q <= p_parity_d;
            p_valid_q  <= p_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_if.p_data   = p_data_q;
    assign out_if.p_parity = p_parity_q;
    assign out_if.p_valid  = p_valid_q;
    assign overrun         = overrun_q;
    assign busy            = (cnt_q != '0);
endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Directed bench for uart_rx_deser_param: each task drives one scenario and checks
// the registered outputs 1 time unit after the clock edge.
module tb_uart_rx_deser_param;
    localparam int MAX_WIDTH = 9;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sampled_bit = 1'b0;
    logic             bit_strobe  = 1'b0;
    logic             deser_en    = 1'b1;
    logic             abort       = 1'b0;
    logic [CNT_W-1:0] data_len    = 4'd8;
    logic             msb_first   = 1'b0;
    logic             overrun_clr = 1'b0;
    logic             overrun;
    logic             busy;

    int errors = 0;
    int checks = 0;

    uart_rx_deser_param_if #(.MAX_WIDTH(MAX_WIDTH)) bus ();

    uart_rx_deser_param #(.MAX_WIDTH(MAX_WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sampled_bit (sampled_bit),
        .bit_strobe  (bit_strobe),
        .deser_en    (deser_en),
        .abort       (abort),
        .data_len    (data_len),
        .msb_first   (msb_first),
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
        .busy        (busy),
        .out_if      (bus.master)
    );

    always #5 clk = ~clk;

    // Bit k of v is the k-th bit sent; strobes are back-to-back.
    task automatic send_bits(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            sampled_bit = v[k];
            bit_strobe  = 1'b1;
            @(posedge clk); #1;
        end
        bit_strobe = 1'b0;
    endtask

    task automatic pop();
        bus.p_ready = 1'b1;
        @(posedge clk); #1;
        bus.p_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.p_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.p_data, bus.p_parity, bus.p_valid, overrun, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h par=%b valid=%b ovr=%b busy=%b, want all 0",
                     bus.p_data, bus.p_parity, bus.p_valid, overrun, busy);
        end
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_lsb8();
        data_len = 4'd8; msb_first = 1'b0;
        send_bits(16'h0065, 7);
        checks++;
        if (bus.p_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lsb8_pre: got valid=%b busy=%b, want valid=0 busy=1", bus.p_valid, busy);
        end
        send_bits(16'h0000, 1);
        checks++;
        if (bus.p_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lsb8_valid: got valid=%b busy=%b, want valid=1 busy=0", bus.p_valid, busy);
        end
        checks++;
        if (bus.p_data !== 9'h065 || bus.p_parity !== 1'b0) begin
            errors++;
            $display("FAIL lsb8_data: got %h par=%b, want 065 par=0", bus.p_data, bus.p_parity);
        end
        pop();
        checks++;
        if (bus.p_valid !== 1'b0 || bus.p_data !== 9'h065) begin
            errors++;
            $display("FAIL lsb8_pop: got valid=%b data=%h, want valid=0 data=065", bus.p_valid, bus.p_data);
        end
        $display("test_lsb8 done: data=%h", bus.p_data);
    endtask

    task automatic test_msb5();
        data_len = 4'd5; msb_first = 1'b1;
        send_bits(16'h001D, 5);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h017 || bus.p_parity !== 1'b0) begin
            errors++;
            $display("FAIL msb5: got valid=%b data=%h par=%b, want 1 017 0", bus.p_valid, bus.p_data, bus.p_parity);
        end
        pop();
        data_len = 4'd2;
        send_bits(16'h001D, 4);
        checks++;
        if (bus.p_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clamp_low_pre: got valid=%b busy=%b, want 0 1", bus.p_valid, busy);
        end
        send_bits(16'h0001, 1);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h017) begin
            errors++;
            $display("FAIL clamp_low: got valid=%b data=%h, want 1 017", bus.p_valid, bus.p_data);
        end
        pop();
        // Above MAX_WIDTH clamps to 9 bits; LSB-first 0x155 has odd parity.
        data_len = 4'd15; msb_first = 1'b0;
        send_bits(16'h0155, 9);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h155 || bus.p_parity !== 1'b1) begin
            errors++;
            $display("FAIL clamp_high: got valid=%b data=%h par=%b, want 1 155 1", bus.p_valid, bus.p_data, bus.p_parity);
        end
        pop();
        $display("test_msb5 done");
    endtask

    task automatic test_abort();
        data_len = 4'd8; msb_first = 1'b0;
        send_bits(16'h0007, 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.p_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b, want 0 0", busy, bus.p_valid);
        end
        send_bits(16'h00A5, 8);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h0A5 || bus.p_parity !== 1'b0) begin
            errors++;
            $display("FAIL abort_word: got valid=%b data=%h par=%b, want 1 0a5 0", bus.p_valid, bus.p_data, bus.p_parity);
        end
        pop();
        $display("test_abort done");
    endtask

    task automatic test_overrun();
        data_len = 4'd8; msb_first = 1'b0;
        send_bits(16'h0011, 8);
        send_bits(16'h0022, 8);
        checks++;
        if (bus.p_data !== 9'h022 || overrun !== 1'b1 || bus.p_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got data=%h ovr=%b valid=%b, want 022 1 1", bus.p_data, overrun, bus.p_valid);
        end
        pop();
        checks++;
        if (bus.p_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got valid=%b ovr=%b, want 0 1", bus.p_valid, overrun);
        end
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: got ovr=%b, want 0", overrun);
        end
        send_bits(16'h0033, 8);
        send_bits(16'h0044, 7);
        bus.p_ready = 1'b1;
        send_bits(16'h0000, 1);
        bus.p_ready = 1'b0;
        checks++;
        if (bus.p_data !== 9'h044 || bus.p_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL pop_and_complete: got data=%h valid=%b ovr=%b, want 044 1 0", bus.p_data, bus.p_valid, overrun);
        end
        pop();
        $display("test_overrun done");
    endtask

    task automatic test_config_change();
        data_len = 4'd8; msb_first = 1'b0;
        send_bits(16'h0003, 2);
        data_len = 4'd6; msb_first = 1'b1;
        send_bits(16'h0000, 4);
        checks++;
        if (bus.p_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_hold: got valid=%b busy=%b, want 0 1", bus.p_valid, busy);
        end
        send_bits(16'h0003, 2);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h0C3) begin
            errors++;
            $display("FAIL cfg_word: got valid=%b data=%h, want 1 0c3", bus.p_valid, bus.p_data);
        end
        data_len = 4'd8; msb_first = 1'b0;
        $display("test_config_change done");
    endtask

    task automatic test_midword_reset();
        send_bits(16'h000F, 4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({bus.p_data, bus.p_parity, bus.p_valid, overrun, busy} !== 13'd0) begin
            errors++;
            $display("FAIL midword_reset: got data=%h par=%b valid=%b ovr=%b busy=%b, want all 0",
                     bus.p_data, bus.p_parity, bus.p_valid, overrun, busy);
        end
        send_bits(16'h003C, 4);
        checks++;
        if (bus.p_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got valid=%b after 4 bits, want 0", bus.p_valid);
        end
        send_bits(16'h0003, 4);
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 9'h03C || bus.p_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_word: got valid=%b data=%h par=%b, want 1 03c 0", bus.p_valid, bus.p_data, bus.p_parity);
        end
        $display("test_midword_reset done");
    endtask

    task automatic test_disabled();
        pop();
        deser_en = 1'b0;
        send_bits(16'h00FF, 8);
        deser_en = 1'b1;
        checks++;
        if (bus.p_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL deser_disabled: got valid=%b busy=%b, want 0 0", bus.p_valid, busy);
        end
        $display("test_disabled done");
    endtask

    initial begin
        bus.p_ready = 1'b0;
        test_reset();
        test_lsb8();
        test_msb5();
        test_abort();
        test_overrun();
        test_config_change();
        test_midword_reset();
        test_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
